bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the console's single-port synchronous work RAM between the 6502 core (requester 0) and the video fetch unit (requester 1). One memory transfer is issued per cycle. The CPU has fixed priority. A starvation guard forces a video grant after a bounded wait. Read data is routed back to the owning requester two cycles after acceptance.

## Interface
Parameters:
- VID_MAX_WAIT, 4 — cycles a pending video request may be refused before it is forced; legal 1..15.
- ADDR_W, 16 — address width.
- DATA_W, 8 — data width.

Ports:
- clk  in  1  — system clock; single clock domain.
- reset  in  1  — synchronous, active-high reset.
- cpu_req  in  1  — CPU transfer request.
- cpu_addr  in  ADDR_W  — CPU address.
- cpu_write  in  1  — 1 = write, 0 = read.
- cpu_wdata  in  DATA_W  — CPU write data.
- cpu_ready  out  1  — CPU request accepted this cycle; combinational.
- cpu_rdata  out  DATA_W  — CPU read data.
- cpu_rvalid  out  1  — cpu_rdata valid, one-cycle pulse.
- vid_req  in  1  — video read request; video never writes.
- vid_addr  in  ADDR_W  — video address.
- vid_ready  out  1  — video request accepted; combinational.
- vid_rdata  out  DATA_W  — video read data.
- vid_rvalid  out  1  — vid_rdata valid, one-cycle pulse.
- mem_addr  out  ADDR_W  — RAM address; registered.
- mem_we  out  1  — RAM write enable; registered.
- mem_wdata  out  DATA_W  — RAM write data; registered.
- mem_rdata  in  DATA_W  — RAM read data, valid one cycle after mem_addr.

## Operation
- Handshake: a transfer is accepted in any cycle where req && ready.
  - After req rises, the requester holds req, addr, write and wdata stable until accepted.
  - ready never asserts without req.
- Grant rule, evaluated each cycle:
  - Neither requesting: no grant.
  - Only one requesting: grant it.
  - Both requesting: grant video if vid_wait == VID_MAX_WAIT; otherwise grant CPU.
- vid_wait (4-bit):
  - Increments each cycle vid_req is high and vid_ready is low; saturates at VID_MAX_WAIT.
  - Clears on a video grant, on vid_req low, or on reset.
- Issue state machine (registered owner of the transfer in flight):
  - States: S_IDLE, S_CPU, S_VID.
  - Next state is the owner granted this cycle; S_IDLE if no grant.
  - Any state may move to any state each cycle.
- Read return:
  - A 2-stage owner/is-read tag pipeline follows each accepted read.
  - At stage 2, mem_rdata is steered to the owner's rdata and that owner's rvalid pulses.
  - Writes carry is-read = 0 and produce no rvalid.
- Idle cycles: mem_we = 0, and mem_addr holds its last value.
- rdata outputs hold their last value when rvalid is low.

## Timing
- Accept in cycle N:
  - mem_addr, mem_we and mem_wdata present the transfer in cycle N+1.
  - For a read, rvalid and rdata are asserted in cycle N+2.
- Throughput: one transfer per cycle; back-to-back grants to either requester are legal.
- Worst-case video latency from vid_req rising to vid_ready is VID_MAX_WAIT cycles under continuous CPU requests.
- After a forced video grant, vid_wait is 0, so the CPU wins the next contended cycle.
- Reset values: cpu_ready = vid_ready = 0, cpu_rvalid = vid_rvalid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata outputs = 0, state = S_IDLE, vid_wait = 0, tag pipeline empty.
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid pulses for them.
  - mem_we is 0 in the cycle after the reset edge.
- Requests asserted while reset is high are not accepted.

## Configuration
- BUS_ARB_STATS_EN defined:
  - Adds output ports stat_cpu_stall[15:0] and stat_vid_stall[15:0].
  - Each counts cycles its req is high and ready is low.
  - Counters saturate at 16'hFFFF and clear on reset.
- Not defined: the ports and counters are absent; arbitration behaviour is identical.

## Structure
- Package bus_pkg holds:
  - owner_e enum {OWN_NONE, OWN_CPU, OWN_VID}, also used for the S_IDLE/S_CPU/S_VID encoding.
  - ADDR_W and DATA_W defaults.
  - Tag struct {owner_e owner; logic is_read}.
- Sub-module sat_counter (parameter WIDTH): saturating increment with synchronous clear. Instantiated twice, only under BUS_ARB_STATS_EN.

## Test plan
- CPU write 8'h5A to 16'h0200, then CPU read of 16'h0200 next cycle:
  - mem_we = 1 with mem_addr = 16'h0200 and mem_wdata = 8'h5A, one cycle after the first accept.
  - cpu_rvalid with cpu_rdata = 8'h5A two cycles after the read accept.
- Video alone reads 16'h4000 (RAM holds 8'h3C): vid_ready in the same cycle; vid_rvalid with vid_rdata = 8'h3C two cycles later; cpu_rvalid stays 0.
- Continuous cpu_req and vid_req, VID_MAX_WAIT = 4:
  - CPU granted 4 cycles, video granted on the 5th, CPU on the 6th.
  - Pattern repeats every 5 cycles.
- Interleaved CPU read 16'h0010 / video read 16'h0011 / CPU write 16'h0012: each rvalid goes only to its owner, in issue order; the write produces no rvalid.
- Reset asserted in the cycle after a CPU read accept: no cpu_rvalid; mem_we = 0 and all outputs at reset values on the next cycle.
- BUS_ARB_STATS_EN defined, contention for 10 cycles, VID_MAX_WAIT = 4: stat_vid_stall = 8, stat_cpu_stall = 2.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the work-RAM arbiter: owner encoding, default bus widths, read-return tag.
package bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    // Issue-state names share the owner encoding.
    localparam owner_e S_IDLE = OWN_NONE;
    localparam owner_e S_CPU  = OWN_CPU;
    localparam owner_e S_VID  = OWN_VID;

    typedef struct packed {
        owner_e owner;
        logic   is_read;
    } tag_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// CPU/video arbiter for the single-port work RAM with a video starvation guard.
// Optional stall counters are built when BUS_ARB_STATS_EN is defined.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned VID_MAX_WAIT = 4,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_stall,
    output logic [15:0]       stat_vid_stall
`endif
);

    localparam int unsigned     WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VID_MAX_WAIT);

    logic [WAIT_W-1:0] vid_wait;
    owner_e            grant;
    owner_e            state;
    logic              s1_is_read;
    tag_t              s2_tag;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    // Grant: CPU wins contention unless video has waited its full budget.
    always_comb begin
        grant = OWN_NONE;
        if (!reset) begin
            if (cpu_req && !(vid_req && (vid_wait == WAIT_MAX))) begin
                grant = OWN_CPU;
            end else if (vid_req) begin
                grant = OWN_VID;
            end
        end
    end

    assign cpu_ready = (grant == OWN_CPU);
    assign vid_ready = (grant == OWN_VID);

    // Issue state, RAM command registers and read-return tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_wait    <= '0;
            state       <= S_IDLE;
            s1_is_read  <= 1'b0;
            s2_tag      <= '{owner: OWN_NONE, is_read: 1'b0};
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            if (!vid_req || vid_ready) begin
                vid_wait <= '0;
            end else if (vid_wait != WAIT_MAX) begin
                vid_wait <= vid_wait + WAIT_W'(1);
            end

            state <= grant;
            case (grant)
                OWN_CPU: begin
                    mem_addr   <= cpu_addr;
                    mem_we     <= cpu_write;
                    s1_is_read <= !cpu_write;
                    if (cpu_write) begin
                        mem_wdata <= cpu_wdata;
                    end
                end
                OWN_VID: begin
                    mem_addr   <= vid_addr;
                    mem_we     <= 1'b0;
                    s1_is_read <= 1'b1;
                end
                default: begin
                    mem_we     <= 1'b0;
                    s1_is_read <= 1'b0;
                end
            endcase

            s2_tag <= '{owner: state, is_read: s1_is_read};

            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (vid_rvalid) begin
                vid_rdata_q <= mem_rdata;
            end
        end
    end

    // RAM data arrives in the same cycle the tag reaches stage 2, so steer it straight through.
    assign cpu_rvalid = s2_tag.is_read && (s2_tag.owner == OWN_CPU);
    assign vid_rvalid = s2_tag.is_read && (s2_tag.owner == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;

`ifdef BUS_ARB_STATS_EN
    sat_counter #(.WIDTH(16)) u_cpu_stall (
        .clk   (clk),
        .clear (reset),
        .inc   (cpu_req && !cpu_ready),
        .count (stat_cpu_stall)
    );

    sat_counter #(.WIDTH(16)) u_vid_stall (
        .clk   (clk),
        .clear (reset),
        .inc   (vid_req && !vid_ready),
        .count (stat_vid_stall)
    );
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a behavioural synchronous RAM.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ready;
    logic [7:0]  vid_rdata;
    logic        vid_rvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef BUS_ARB_STATS_EN
    logic [15:0] stat_cpu_stall;
    logic [15:0] stat_vid_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:65535];

    always #5 clk = ~clk;

    bus_arbiter #(.VID_MAX_WAIT(4), .ADDR_W(16), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ready  (vid_ready),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef BUS_ARB_STATS_EN
        ,
        .stat_cpu_stall (stat_cpu_stall),
        .stat_vid_stall (stat_vid_stall)
`endif
    );

    // Synchronous RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_write = 1'b0;
        cpu_wdata = 8'h00;
        vid_req   = 1'b0;
        vid_addr  = 16'h0000;
    endtask

    initial begin
        ram[16'h4000] = 8'h3C;
        ram[16'h0010] = 8'hA1;
        ram[16'h0011] = 8'hB2;
        ram[16'h0100] = 8'h11;
        ram[16'h0101] = 8'h22;
        mem_rdata = 8'h00;
        reset = 1'b1;
        idle_inputs();
        step();
        step();

        // Reset state
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        check("rst_vid_ready", 32'(vid_ready), 32'h0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_vid_rdata", 32'(vid_rdata), 32'h0);
        step();

        // CPU write 5A to 0200, then read it back
        cpu_req = 1'b1; cpu_addr = 16'h0200; cpu_write = 1'b1; cpu_wdata = 8'h5A;
        @(negedge clk);
        check("wr_cpu_ready", 32'(cpu_ready), 32'h1);
        step();
        cpu_write = 1'b0; cpu_wdata = 8'h00;
        @(negedge clk);
        check("rd_cpu_ready", 32'(cpu_ready), 32'h1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h0200);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
        step();
        idle_inputs();
        @(negedge clk);
        check("rd_mem_we", 32'(mem_we), 32'h0);
        check("rd_mem_addr", 32'(mem_addr), 32'h0200);
        check("rd_early_rvalid", 32'(cpu_rvalid), 32'h0);
        step();
        @(negedge clk);
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'h5A);
        check("rd_vid_rvalid", 32'(vid_rvalid), 32'h0);
        step();
        @(negedge clk);
        check("rd_rvalid_pulse", 32'(cpu_rvalid), 32'h0);
        check("rd_rdata_hold", 32'(cpu_rdata), 32'h5A);
        check("idle_mem_addr_hold", 32'(mem_addr), 32'h0200);
        step();

        // Video alone reads 4000
        vid_req = 1'b1; vid_addr = 16'h4000;
        @(negedge clk);
        check("vid_ready", 32'(vid_ready), 32'h1);
        check("vid_cpu_ready", 32'(cpu_ready), 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check("vid_mem_addr", 32'(mem_addr), 32'h4000);
        check("vid_mem_we", 32'(mem_we), 32'h0);
        step();
        @(negedge clk);
        check("vid_rvalid", 32'(vid_rvalid), 32'h1);
        check("vid_rdata", 32'(vid_rdata), 32'h3C);
        check("vid_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        step();
        @(negedge clk);
        check("vid_rvalid_pulse", 32'(vid_rvalid), 32'h0);
        step();

        // Contention for 10 cycles: video forced every 5th cycle
        cpu_req = 1'b1; cpu_addr = 16'h0100; cpu_write = 1'b0;
        vid_req = 1'b1; vid_addr = 16'h0101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("cont_cpu_ready_%0d", i), 32'(cpu_ready), (i % 5 == 4) ? 32'h0 : 32'h1);
            check($sformatf("cont_vid_ready_%0d", i), 32'(vid_ready), (i % 5 == 4) ? 32'h1 : 32'h0);
            step();
        end
        idle_inputs();
`ifdef BUS_ARB_STATS_EN
        @(negedge clk);
        check("stat_vid_stall", 32'(stat_vid_stall), 32'd8);
        check("stat_cpu_stall", 32'(stat_cpu_stall), 32'd2);
`endif
        step();
        step();
        step();

        // Interleaved CPU read / video read / CPU write
        cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_write = 1'b0;
        @(negedge clk);
        check("il_cpu_ready", 32'(cpu_ready), 32'h1);
        step();
        cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h0011;
        @(negedge clk);
        check("il_vid_ready", 32'(vid_ready), 32'h1);
        step();
        vid_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0012; cpu_write = 1'b1; cpu_wdata = 8'h77;
        @(negedge clk);
        check("il_wr_ready", 32'(cpu_ready), 32'h1);
        check("il_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("il_cpu_rdata", 32'(cpu_rdata), 32'hA1);
        check("il_vid_rvalid0", 32'(vid_rvalid), 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check("il_vid_rvalid", 32'(vid_rvalid), 32'h1);
        check("il_vid_rdata", 32'(vid_rdata), 32'hB2);
        check("il_cpu_rvalid1", 32'(cpu_rvalid), 32'h0);
        check("il_wr_mem_we", 32'(mem_we), 32'h1);
        check("il_wr_mem_addr", 32'(mem_addr), 32'h0012);
        step();
        @(negedge clk);
        check("il_wr_no_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("il_wr_no_vid_rvalid", 32'(vid_rvalid), 32'h0);
        check("il_cpu_rdata_hold", 32'(cpu_rdata), 32'hA1);
        step();

        // Reset one cycle after a CPU read accept
        cpu_req = 1'b1; cpu_addr = 16'h0200; cpu_write = 1'b0;
        @(negedge clk);
        check("mr_cpu_ready", 32'(cpu_ready), 32'h1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("mr_ready_in_reset", 32'(cpu_ready), 32'h0);
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("mr_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("mr_mem_we", 32'(mem_we), 32'h0);
        check("mr_mem_addr", 32'(mem_addr), 32'h0);
        check("mr_mem_wdata", 32'(mem_wdata), 32'h0);
        check("mr_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("mr_vid_rdata", 32'(vid_rdata), 32'h0);
`ifdef BUS_ARB_STATS_EN
        check("mr_stat_cpu", 32'(stat_cpu_stall), 32'h0);
        check("mr_stat_vid", 32'(stat_vid_stall), 32'h0);
`endif
        step();
        @(negedge clk);
        check("mr_cpu_rvalid_late", 32'(cpu_rvalid), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
